// File: rtl/fir2p_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir2p_stream_ctrl_if
// Brief    : valid/ready sample stream with frame delimiter
// Revision : 1.0
// ============================================================================
interface fir2p_stream_ctrl_if #(
    parameter int DW = 16
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/fir2p_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir2p_stream_ctrl
// Brief    : pairs a serial sample stream onto a 2-parallel FIR core and
//            re-serialises its result pairs, padding odd frames
// Revision : 1.0
// ============================================================================
module fir2p_stream_ctrl #(
    parameter int DW         = 16,
    parameter int PBUF_DEPTH = 2,
    parameter int CNT_W      = 17
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fir2p_stream_ctrl_if.slave    s,
    fir2p_stream_ctrl_if.master   m,
    output logic [DW-1:0]         core_x2k,
    output logic [DW-1:0]         core_x2k_1,
    output logic                  core_en,
    output logic                  core_clr,
    input  wire logic [DW-1:0]    core_y2k,
    input  wire logic [DW-1:0]    core_y2k_1,
    output logic                  busy,
    output logic [CNT_W-1:0]      smp_cnt
);

    localparam int c_PTR_W = (PBUF_DEPTH > 1) ? $clog2(PBUF_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(PBUF_DEPTH + 1);
    localparam int c_OUT_W = c_CNT_W + 1;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t               r_state;
    logic [DW-1:0]        r_hold;
    logic                 r_half;
    logic [DW-1:0]        r_x2k;
    logic [DW-1:0]        r_x2k_1;
    logic                 r_en;
    logic                 r_en_pad;
    logic                 r_en_last;
    logic                 r_cap;
    logic                 r_cap_pad;
    logic                 r_cap_last;
    logic [DW-1:0]        r_even  [PBUF_DEPTH];
    logic [DW-1:0]        r_odd   [PBUF_DEPTH];
    logic                 r_tpad  [PBUF_DEPTH];
    logic                 r_tlast [PBUF_DEPTH];
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_phase;
    logic                 r_last_done;
    logic [CNT_W-1:0]     r_smp;

    logic [c_OUT_W-1:0]   w_outst;
    logic                 w_credit;
    logic                 w_s_ready;
    logic                 w_acc;
    logic                 w_m_valid;
    logic                 w_mhs;
    logic                 w_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(PBUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Pairs in the core pipeline count against buffer space so a capture never overflows.
    assign w_outst   = c_OUT_W'(r_cnt) + c_OUT_W'(r_en) + c_OUT_W'(r_cap);
    assign w_credit  = w_outst < c_OUT_W'(PBUF_DEPTH);
    assign w_s_ready = (r_state == ST_RUN) && (!r_half || w_credit);
    assign w_acc     = s.valid && w_s_ready;
    assign w_m_valid = (r_cnt != '0);
    assign w_mhs     = w_m_valid && m.ready;
    assign w_pop     = w_mhs && (r_phase || r_tpad[r_rd]);

    assign s.ready    = w_s_ready;
    assign m.valid    = w_m_valid;
    assign m.data     = r_phase ? r_odd[r_rd] : r_even[r_rd];
    assign m.last     = w_m_valid && (r_phase ? r_tlast[r_rd] : r_tpad[r_rd]);
    assign core_x2k   = r_x2k;
    assign core_x2k_1 = r_x2k_1;
    assign core_en    = r_en;
    // Gated with rst so every output reads 0 while reset is held.
    assign core_clr   = (r_state == ST_CLR) && !rst;
    assign busy       = (r_state != ST_RUN) && !rst;
    assign smp_cnt    = r_smp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLR;
            r_hold      <= '0;
            r_half      <= 1'b0;
            r_x2k       <= '0;
            r_x2k_1     <= '0;
            r_en        <= 1'b0;
            r_en_pad    <= 1'b0;
            r_en_last   <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_pad   <= 1'b0;
            r_cap_last  <= 1'b0;
            for (int i = 0; i < PBUF_DEPTH; i++) begin
                r_even[i]  <= '0;
                r_odd[i]   <= '0;
                r_tpad[i]  <= 1'b0;
                r_tlast[i] <= 1'b0;
            end
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_last_done <= 1'b0;
            r_smp       <= '0;
        end else begin
            r_en       <= 1'b0;
            r_cap      <= r_en;
            r_cap_pad  <= r_en_pad;
            r_cap_last <= r_en_last;

            if (r_cap) begin
                r_even[r_wr]  <= core_y2k;
                r_odd[r_wr]   <= core_y2k_1;
                r_tpad[r_wr]  <= r_cap_pad;
                r_tlast[r_wr] <= r_cap_last;
                r_wr          <= f_next(r_wr);
            end

            if (w_pop) begin
                r_rd    <= f_next(r_rd);
                r_phase <= 1'b0;
            end else if (w_mhs) begin
                r_phase <= 1'b1;
            end

            case ({r_cap, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_mhs && m.last)
                r_last_done <= 1'b1;

            case (r_state)
                ST_CLR: begin
                    r_hold      <= '0;
                    r_half      <= 1'b0;
                    r_smp       <= '0;
                    r_last_done <= 1'b0;
                    r_state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_acc) begin
                        r_smp <= r_smp + CNT_W'(1);
                        if (!r_half) begin
                            r_hold <= s.data;
                            r_half <= 1'b1;
                            if (s.last)
                                r_state <= ST_PAD;
                        end else begin
                            r_x2k     <= r_hold;
                            r_x2k_1   <= s.data;
                            r_en      <= 1'b1;
                            r_en_pad  <= 1'b0;
                            r_en_last <= s.last;
                            r_half    <= 1'b0;
                            if (s.last)
                                r_state <= ST_WAIT;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_credit) begin
                        r_x2k     <= r_hold;
                        r_x2k_1   <= '0;
                        r_en      <= 1'b1;
                        r_en_pad  <= 1'b1;
                        r_en_last <= 1'b1;
                        r_half    <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_outst == '0 && r_last_done)
                        r_state <= ST_CLR;
                end
                default: r_state <= ST_CLR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir2p_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir2p_stream_ctrl
// Brief    : directed bench for fir2p_stream_ctrl with an identity core model
// Revision : 1.0
// ============================================================================
module tb_fir2p_stream_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] x2k, x2k_1;
    logic [DW-1:0] y2k = '0, y2k_1 = '0;
    logic          en, clr, busy;
    logic [16:0]   smp_cnt;

    always #5 clk = ~clk;

    fir2p_stream_ctrl_if #(.DW(DW)) s_if ();
    fir2p_stream_ctrl_if #(.DW(DW)) m_if ();

    fir2p_stream_ctrl #(.DW(DW), .PBUF_DEPTH(2), .CNT_W(17)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s_if),
        .m          (m_if),
        .core_x2k   (x2k),
        .core_x2k_1 (x2k_1),
        .core_en    (en),
        .core_clr   (clr),
        .core_y2k   (y2k),
        .core_y2k_1 (y2k_1),
        .busy       (busy),
        .smp_cnt    (smp_cnt)
    );

    // Identity core: y = x, one core_en of latency.
    always @(posedge clk) begin
        if (clr) begin
            y2k   <= '0;
            y2k_1 <= '0;
        end else if (en) begin
            y2k   <= x2k;
            y2k_1 <= x2k_1;
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            n_clr    = 0;
    int            n_iss    = 0;
    int            n_pop    = 0;
    int            max_out  = 0;
    logic          bphase   = 1'b0;
    logic [DW-1:0] px[$], po[$], od[$];
    logic          ol[$];
    int            acc_cyc[$], oc[$];
    logic [DW-1:0] exp_d [8];
    logic [DW-1:0] exp_x [4];
    logic [DW-1:0] exp_o [4];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bphase = 1'b0;
            n_iss  = 0;
            n_pop  = 0;
        end else begin
            if (clr) n_clr++;
            if (en) begin
                px.push_back(x2k);
                po.push_back(x2k_1);
                n_iss++;
            end
            if (s_if.valid && s_if.ready) acc_cyc.push_back(cyc);
            if (m_if.valid && m_if.ready) begin
                od.push_back(m_if.data);
                ol.push_back(m_if.last);
                oc.push_back(cyc);
                if (bphase || m_if.last) begin
                    n_pop++;
                    bphase = 1'b0;
                end else begin
                    bphase = 1'b1;
                end
            end
            if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        px.delete(); po.delete(); od.delete(); ol.delete();
        acc_cyc.delete(); oc.delete();
        n_clr   = 0;
        max_out = 0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int to = 0;
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.last  = l;
        @(negedge clk);
        while (!s_if.ready && to < 100) begin
            to++;
            @(negedge clk);
        end
        if (to >= 100) check_eq("send_timeout", 32'(to), 0);
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic wait_idle();
        int to = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && s_if.ready) && to < 200) begin
            to++;
            @(negedge clk);
        end
        if (to >= 200) check_eq("idle_timeout", 32'(to), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_pairs(input int n);
        check_eq("pair_count", 32'(px.size()), 32'(n));
        for (int i = 0; i < n && i < px.size(); i++) begin
            check_eq($sformatf("pair%0d_x2k", i),   32'(px[i]), 32'(exp_x[i]));
            check_eq($sformatf("pair%0d_x2k_1", i), 32'(po[i]), 32'(exp_o[i]));
        end
    endtask

    task automatic check_stream(input int n);
        check_eq("out_count", 32'(od.size()), 32'(n));
        for (int i = 0; i < n && i < od.size(); i++) begin
            check_eq($sformatf("out%0d_data", i), 32'(od[i]), 32'(exp_d[i]));
            check_eq($sformatf("out%0d_last", i), 32'(ol[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;

        // Reset and first CLR pulse
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {s_if.ready, m_if.valid, m_if.last, en, clr, busy}, 0);
        check_eq("rst_cnt", 32'(smp_cnt), 0);
        check_eq("rst_data", {x2k, x2k_1, m_if.data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_clr", {clr, s_if.ready}, 2'b10);
        @(negedge clk);
        check_eq("run_ready", {clr, s_if.ready}, 2'b01);
        check_eq("run_cnt", 32'(smp_cnt), 0);
        @(posedge clk);
        #1;

        // Even frame 1..4
        m_if.ready = 1'b1;
        clr_log();
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
        wait_idle();
        exp_x[0] = 1; exp_o[0] = 2; exp_x[1] = 3; exp_o[1] = 4;
        check_pairs(2);
        for (int i = 0; i < 4; i++) exp_d[i] = DW'(i + 1);
        check_stream(4);
        if (acc_cyc.size() >= 2 && oc.size() >= 2) begin
            check_eq("lat_even", 32'(oc[0] - acc_cyc[1]), 3);
            check_eq("lat_odd",  32'(oc[1] - acc_cyc[1]), 4);
        end else begin
            check_eq("lat_samples", 32'(oc.size()), 2);
        end
        check_eq("t2_clr_pulses", 32'(n_clr), 1);

        // Odd frame 5,6,7 with pad
        clr_log();
        send(5, 0); send(6, 0); send(7, 1);
        @(negedge clk);
        check_eq("t3_smp_cnt", 32'(smp_cnt), 3);
        @(posedge clk);
        #1;
        wait_idle();
        exp_x[0] = 5; exp_o[0] = 6; exp_x[1] = 7; exp_o[1] = 0;
        check_pairs(2);
        exp_d[0] = 5; exp_d[1] = 6; exp_d[2] = 7;
        check_stream(3);

        // Backpressure with 8 samples
        m_if.ready = 1'b0;
        clr_log();
        for (int i = 1; i <= 5; i++) send(DW'(i), 1'b0);
        s_if.valid = 1'b1;
        s_if.data  = 6;
        repeat (4) @(negedge clk);
        check_eq("t4_ready_full", 32'(s_if.ready), 0);
        check_eq("t4_pairs_held", 32'(px.size()), 2);
        @(posedge clk);
        #1;
        m_if.ready = 1'b1;
        send(6, 0); send(7, 0); send(8, 1);
        wait_idle();
        for (int i = 0; i < 8; i++) exp_d[i] = DW'(i + 1);
        check_stream(8);
        check_eq("t4_max_outstanding", 32'(max_out), 2);

        // Reset mid-frame discards the held sample
        clr_log();
        send(9, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();
        check_eq("t5_clr_pulses", 32'(n_clr), 1);
        check_eq("t5_no_issue", 32'(px.size()), 0);
        clr_log();
        send(10, 0); send(11, 1);
        wait_idle();
        exp_x[0] = 10; exp_o[0] = 11;
        check_pairs(1);
        exp_d[0] = 10; exp_d[1] = 11;
        check_stream(2);

        // Single-sample frame
        clr_log();
        send(16'hFFF9, 1);
        @(negedge clk);
        check_eq("t6_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        wait_idle();
        exp_x[0] = 16'hFFF9; exp_o[0] = 0;
        check_pairs(1);
        exp_d[0] = 16'hFFF9;
        check_stream(1);
        check_eq("t6_clr_pulses", 32'(n_clr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
